store_buffer: RTL and testbench

- Post-retirement store queue between the retire stage and data memory.
- Retired stores enter in program order and drain to memory one at a time over a req/gnt handshake.
- Asserts `sb_full`, which drives the ROB `retire_disable` input.
- Also supplies store-to-load forwarding for younger loads.

---
 rtl/sys_defs.sv | 38 +++
 rtl/sb_fwd_match.sv | 46 ++++
 rtl/store_buffer.sv | 123 ++++++++++++
 tb/tb_store_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared store buffer types, sizes and helpers
// Entry layout, memory size codes and drain states used by store_buffer and sb_fwd_match.
`ifndef SB_DEPTH
`define SB_DEPTH 4
`endif

package sys_defs;

  localparam int SYS_XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } MEM_SIZE;

  typedef struct packed {
    logic                valid;
    logic [SYS_XLEN-1:0] addr;
    logic [SYS_XLEN-1:0] data;
    MEM_SIZE             size;
  } SB_ENTRY;

  typedef enum logic {
    SB_IDLE,
    SB_REQ
  } SB_STATE;

  // Code 3 is unused by the pipeline; treat it as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - overlap/coverage test and byte shift for one store entry
// Purely combinational; the parent picks the youngest overlapping entry.
module sb_fwd_match
  import sys_defs::*;
#(
  parameter int XLEN = SYS_XLEN
) (
  input  logic            valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  input  logic [1:0]      st_size,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [1:0]      ld_size,
  output logic            overlap,
  output logic            covers,
  output logic [XLEN-1:0] data
);

  logic [XLEN:0]   st_lo, ld_lo, st_hi, ld_hi;
  logic [1:0]      offset;
  logic [XLEN-1:0] shifted, mask;

  // One extra bit keeps range ends near the top of the address space from wrapping.
  assign st_lo = {1'b0, st_addr};
  assign ld_lo = {1'b0, ld_addr};
  assign st_hi = st_lo + (XLEN+1)'(size_bytes(st_size));
  assign ld_hi = ld_lo + (XLEN+1)'(size_bytes(ld_size));

  assign overlap = valid && (st_lo < ld_hi) && (ld_lo < st_hi);
  assign covers  = overlap && (st_lo <= ld_lo) && (ld_hi <= st_hi);

  // Covered loads start at most three bytes into the store, so two bits suffice.
  assign offset  = ld_addr[1:0] - st_addr[1:0];
  assign shifted = st_data >> {offset, 3'b000};

  always_comb begin
    case (ld_size)
      2'd0:    mask = XLEN'(8'hFF);
      2'd1:    mask = XLEN'(16'hFFFF);
      default: mask = '1;
    endcase
  end

  assign data = shifted & mask;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-retirement store queue with memory drain and load forwarding
// Circular buffer drained one store per grant; forwarding resolves youngest-first.
module store_buffer
  import sys_defs::*;
#(
  parameter int SB_DEPTH = `SB_DEPTH,
  parameter int XLEN     = SYS_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rt_st_valid,
  input  logic [XLEN-1:0] rt_st_addr,
  input  logic [XLEN-1:0] rt_st_data,
  input  logic [1:0]      rt_st_size,
  output logic            sb_full,
  output logic            sb_empty,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_data,
  output logic [1:0]      mem_size,
  input  logic            mem_gnt,
  input  logic            ld_valid,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [1:0]      ld_size,
  output logic            fwd_hit,
  output logic [XLEN-1:0] fwd_data,
  output logic            fwd_stall
);

  localparam int IW = $clog2(SB_DEPTH);

  SB_ENTRY           entries [SB_DEPTH];
  logic    [IW:0]    head, tail, count;
  logic    [IW-1:0]  head_idx, tail_idx;
  SB_STATE           state, state_next;
  logic              push, pop;

  assign count    = tail - head;
  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign sb_full  = (count == (IW+1)'(SB_DEPTH));
  assign sb_empty = (count == '0);
  assign push     = rt_st_valid && !sb_full;
  assign pop      = (state == SB_REQ) && mem_gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      state <= SB_IDLE;
      for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head <= head + 1'b1;
      end
      if (push) begin
        entries[tail_idx] <= '{valid: 1'b1, addr: rt_st_addr, data: rt_st_data,
                               size: MEM_SIZE'(rt_st_size)};
        tail <= tail + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    case (state)
      SB_IDLE: if (!sb_empty) state_next = SB_REQ;
      SB_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt && count <= (IW+1)'(1)) state_next = SB_IDLE;
      end
      default: state_next = SB_IDLE;
    endcase
  end

  assign mem_addr = entries[head_idx].addr;
  assign mem_data = entries[head_idx].data;
  assign mem_size = entries[head_idx].size;

  logic [SB_DEPTH-1:0] ov, cv;
  logic [XLEN-1:0]     fd [SB_DEPTH];

  for (genvar g = 0; g < SB_DEPTH; g++) begin : g_match
    sb_fwd_match #(.XLEN(XLEN)) u_match (
      .valid   (entries[g].valid),
      .st_addr (entries[g].addr),
      .st_data (entries[g].data),
      .st_size (entries[g].size),
      .ld_addr (ld_addr),
      .ld_size (ld_size),
      .overlap (ov[g]),
      .covers  (cv[g]),
      .data    (fd[g])
    );
  end

  logic            sel_ov, sel_cv;
  logic [XLEN-1:0] sel_data;
  logic [IW-1:0]   idx;

  // Walk oldest to youngest so the youngest overlapping entry wins.
  always_comb begin
    sel_ov   = 1'b0;
    sel_cv   = 1'b0;
    sel_data = '0;
    idx      = head_idx;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_idx + IW'(k);
      if (ov[idx]) begin
        sel_ov   = 1'b1;
        sel_cv   = cv[idx];
        sel_data = fd[idx];
      end
    end
    fwd_hit   = ld_valid && sel_ov && sel_cv;
    fwd_stall = ld_valid && sel_ov && !sel_cv;
    fwd_data  = fwd_hit ? sel_data : '0;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer
// Expected drains are queued at push and compared on each granted request.
module tb_store_buffer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rt_st_valid = 1'b0;
  logic [31:0] rt_st_addr = '0;
  logic [31:0] rt_st_data = '0;
  logic [1:0]  rt_st_size = '0;
  logic        sb_full, sb_empty, mem_req;
  logic [31:0] mem_addr, mem_data;
  logic [1:0]  mem_size;
  logic        mem_gnt = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [1:0]  ld_size = '0;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt   = 0;
  logic req_m = 1'b0;
  exp_t sb_q[$];

  store_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .rt_st_valid (rt_st_valid),
    .rt_st_addr  (rt_st_addr),
    .rt_st_data  (rt_st_data),
    .rt_st_size  (rt_st_size),
    .sb_full     (sb_full),
    .sb_empty    (sb_empty),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_size    (mem_size),
    .mem_gnt     (mem_gnt),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_size     (ld_size),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .fwd_stall   (fwd_stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; checks status, drains and optionally forwarding.
  task automatic step(input logic push, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic gnt,
                      input logic ldv, input logic [31:0] la, input logic [1:0] lsz,
                      input logic chkf, input logic eh, input logic es, input logic [31:0] ed);
    logic push_ok, pop, nreq;
    exp_t e;
    @(negedge clock);
    rt_st_valid = push; rt_st_addr = a; rt_st_data = d; rt_st_size = sz;
    mem_gnt = gnt; ld_valid = ldv; ld_addr = la; ld_size = lsz;
    #1;
    chk("sb_full", sb_full, cnt == 4);
    chk("sb_empty", sb_empty, cnt == 0);
    chk("mem_req", mem_req, req_m);
    pop = req_m && gnt;
    if (pop && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_data", mem_data, e.data);
      chk("mem_size", mem_size, e.size);
    end
    if (chkf) begin
      chk("fwd_hit", fwd_hit, eh);
      chk("fwd_stall", fwd_stall, es);
      chk("fwd_data", fwd_data, ed);
    end
    push_ok = push && (cnt < 4);
    if (!req_m) nreq = (cnt != 0);
    else if (gnt) nreq = (cnt > 1);
    else nreq = 1'b1;
    req_m = nreq;
    cnt = cnt + int'(push_ok) - int'(pop);
    if (push_ok) sb_q.push_back('{addr: a, data: d, size: sz});
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                         input logic gnt);
    step(1'b1, a, d, sz, gnt, 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input logic gnt);
    step(1'b0, '0, '0, 2'd0, gnt, 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load(input logic [31:0] la, input logic [1:0] lsz,
                      input logic eh, input logic es, input logic [31:0] ed);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, la, lsz, 1'b1, eh, es, ed);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'd2;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_full", sb_full, 1'b0);
    chk("rst_empty", sb_empty, 1'b1);
    chk("rst_fwd_hit", fwd_hit, 1'b0);
    chk("rst_fwd_stall", fwd_stall, 1'b0);
    chk("rst_fwd_data", fwd_data, 32'h0);
    ld_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Reset while draining two entries
    push_st(32'h500, 32'h5555_0000, 2'd2, 1'b0);
    push_st(32'h504, 32'h5555_0004, 2'd2, 1'b0);
    idle(1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_empty", sb_empty, 1'b1);
    chk("mid_rst_full", sb_full, 1'b0);
    cnt = 0; req_m = 1'b0; sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) idle(1'b1);

    // Fill to full; fifth push is illegal and must be dropped
    for (int i = 0; i < 4; i++)
      push_st(32'h100 + 32'(4 * i), 32'hDEAD_0100 + 32'(4 * i), 2'd2, 1'b0);
    push_st(32'h110, 32'hBAD0_0110, 2'd2, 1'b0);
    idle(1'b0);
    chk("full_hold_addr", mem_addr, 32'h100);
    chk("full_flag", sb_full, 1'b1);

    // Back-to-back drain
    repeat (4) idle(1'b1);
    idle(1'b0);
    chk("drain_empty", sb_empty, 1'b1);
    chk("drain_req", mem_req, 1'b0);

    // Push while full on a grant cycle, then push+grant with wrapped tail
    for (int i = 0; i < 4; i++)
      push_st(32'h600 + 32'(4 * i), 32'hC0DE_0600 + 32'(4 * i), 2'd1, 1'b0);
    push_st(32'h610, 32'hBAD0_0610, 2'd2, 1'b1);
    push_st(32'h614, 32'hC0DE_0614, 2'd0, 1'b1);
    chk("wrap_count3_notfull", sb_full, 1'b0);
    repeat (3) idle(1'b1);
    idle(1'b0);
    chk("wrap_empty", sb_empty, 1'b1);

    // Forwarding
    push_st(32'h200, 32'hAABB_CCDD, 2'd2, 1'b0);
    push_st(32'h201, 32'h0000_0011, 2'd0, 1'b0);
    load(32'h200, 2'd2, 1'b0, 1'b1, 32'h0);
    load(32'h201, 2'd0, 1'b1, 1'b0, 32'h11);
    load(32'h202, 2'd1, 1'b1, 1'b0, 32'hAABB);
    load(32'h203, 2'd0, 1'b1, 1'b0, 32'hAA);
    load(32'h300, 2'd2, 1'b0, 1'b0, 32'h0);
    step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 32'h201, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (2) idle(1'b1);
    idle(1'b0);
    chk("final_empty", sb_empty, 1'b1);
    chk("final_queue", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
